// File: rtl/vga_tile_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bombman_vga_pkg
//  Description : Shared constants and helpers for the BombMan VGA tile
//                renderer: cell display codes, game-over encodings, default
//                640x480@60 timing and the code->RGB palette.
//  Revision    : 1.0 - initial release
// ============================================================================
package bombman_vga_pkg;

    // Default timing: 640x480, 25 MHz pixel clock, 800 x 521 total.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 29;
    localparam int DEF_GRID_W   = 10;
    localparam int DEF_GRID_H   = 10;
    localparam int DEF_TILE_W   = 64;
    localparam int DEF_TILE_H   = 48;

    // Merged per-cell display code.
    localparam logic [2:0] CODE_EMPTY      = 3'd0;
    localparam logic [2:0] CODE_BLOCK      = 3'd1;
    localparam logic [2:0] CODE_P1         = 3'd2;
    localparam logic [2:0] CODE_P2         = 3'd3;
    localparam logic [2:0] CODE_BOMB_NEW   = 3'd4;
    localparam logic [2:0] CODE_BOMB_ARMED = 3'd5;
    localparam logic [2:0] CODE_EXPLODE    = 3'd6;

    // game_over input encoding.
    localparam logic [1:0] GO_PLAYING = 2'd0;
    localparam logic [1:0] GO_P1_WINS = 2'd1;
    localparam logic [1:0] GO_P2_WINS = 2'd2;
    localparam logic [1:0] GO_DRAW    = 2'd3;

    // Arena content has priority over a bomb sitting in the same cell.
    function automatic logic [2:0] cell_code(input logic [1:0] ac, input logic [1:0] bc);
        logic [2:0] code;
        code = CODE_EMPTY;
        case (ac)
            2'd1:    code = CODE_BLOCK;
            2'd2:    code = CODE_P1;
            2'd3:    code = CODE_P2;
            default: begin
                case (bc)
                    2'd1:    code = CODE_BOMB_NEW;
                    2'd2:    code = CODE_BOMB_ARMED;
                    2'd3:    code = CODE_EXPLODE;
                    default: code = CODE_EMPTY;
                endcase
            end
        endcase
        return code;
    endfunction

    // {red[2:0], green[2:0], blue[1:0]}; red fades as the code rises.
    function automatic logic [7:0] palette(input logic [2:0] code);
        if (code > CODE_EXPLODE) begin
            return 8'h00;
        end
        return {3'd7 - code, 3'b111, 2'b11};
    endfunction

    function automatic logic [7:0] game_over_colour(input logic [1:0] go);
        logic [7:0] rgb;
        case (go)
            GO_P1_WINS: rgb = 8'b111_000_00;
            GO_P2_WINS: rgb = 8'b000_000_11;
            GO_DRAW:    rgb = 8'b100_100_10;
            default:    rgb = 8'h00;
        endcase
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_tile_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_tile_renderer_if
//  Description : Game-state inputs and video outputs of the tile renderer.
//                master : game/display side (drives arena, bomb, game_over)
//                slave  : renderer (drives hsync, vsync, RGB, active,
//                         frame_start)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_tile_renderer_if #(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10
);
    logic [2*GRID_W*GRID_H-1:0] arena;
    logic [2*GRID_W*GRID_H-1:0] bomb;
    logic [1:0]                 game_over;
    logic                       hsync;
    logic                       vsync;
    logic [2:0]                 red;
    logic [2:0]                 green;
    logic [1:0]                 blue;
    logic                       active;
    logic                       frame_start;

    modport master (
        output arena, bomb, game_over,
        input  hsync, vsync, red, green, blue, active, frame_start
    );

    modport slave (
        input  arena, bomb, game_over,
        output hsync, vsync, red, green, blue, active, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_tile_renderer_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Beam counters for the tile renderer. Produces raw (stage 0)
//                sync/visible decodes, line/frame wrap flags and a registered
//                frame_start pulse that is high exactly while hc=0,
//                vc=V_ACTIVE.
//  Ports       : pixel_clk, rst_n (async, active-low)
//                o_h_last/o_v_last : hc / vc at final count
//                o_hsync/o_vsync   : active-low syncs for current counters
//                o_visible         : counters inside the visible region
//                o_frame_start     : one-cycle pulse at first vblank line
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29
) (
    input  logic pixel_clk,
    input  logic rst_n,
    output logic o_h_last,
    output logic o_v_last,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_visible,
    output logic o_frame_start
);
    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HC_W    = $clog2(c_H_TOTAL);
    localparam int c_VC_W    = $clog2(c_V_TOTAL);

    localparam logic [c_HC_W-1:0] c_H_LAST   = c_HC_W'(c_H_TOTAL - 1);
    localparam logic [c_HC_W-1:0] c_H_VIS    = c_HC_W'(H_ACTIVE);
    localparam logic [c_HC_W-1:0] c_HS_START = c_HC_W'(H_ACTIVE + H_FP);
    localparam logic [c_HC_W-1:0] c_HS_END   = c_HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VC_W-1:0] c_V_LAST   = c_VC_W'(c_V_TOTAL - 1);
    localparam logic [c_VC_W-1:0] c_V_VIS    = c_VC_W'(V_ACTIVE);
    localparam logic [c_VC_W-1:0] c_VS_START = c_VC_W'(V_ACTIVE + V_FP);
    localparam logic [c_VC_W-1:0] c_VS_END   = c_VC_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_HC_W-1:0] r_hc;
    logic [c_VC_W-1:0] r_vc;
    logic              r_frame_start;
    logic [c_HC_W-1:0] w_hc_next;
    logic [c_VC_W-1:0] w_vc_next;

    assign o_h_last  = (r_hc == c_H_LAST);
    assign o_v_last  = (r_vc == c_V_LAST);
    assign w_hc_next = o_h_last ? '0 : r_hc + 1'b1;
    assign w_vc_next = o_h_last ? (o_v_last ? '0 : r_vc + 1'b1) : r_vc;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hc          <= w_hc_next;
            r_vc          <= w_vc_next;
            // Decoded from the next count so the pulse lines up with hc=0,vc=V_ACTIVE.
            r_frame_start <= (w_hc_next == '0) && (w_vc_next == c_V_VIS);
        end
    end

    assign o_hsync       = !((r_hc >= c_HS_START) && (r_hc < c_HS_END));
    assign o_vsync       = !((r_vc >= c_VS_START) && (r_vc < c_VS_END));
    assign o_visible     = (r_hc < c_H_VIS) && (r_vc < c_V_VIS);
    assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: rtl/vga_tile_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_tile_renderer
//  Description : VGA tile-map renderer. Snapshots arena/bomb/game_over once
//                per frame, tracks tile column/row with incremental counters
//                and produces registered RGB two clocks after the beam
//                counters, with hsync/vsync/active delayed to match.
//  Ports       : pixel_clk, rst_n (async, active-low)
//                vga (slave) : arena, bomb, game_over in;
//                              hsync, vsync, red, green, blue, active,
//                              frame_start out
//  Options     : VGA_GRID_LINES_EN - black outline on the first pixel column
//                and first line of every tile while playing.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_tile_renderer
    import bombman_vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int TILE_W   = DEF_TILE_W,
    parameter int TILE_H   = DEF_TILE_H
) (
    input  logic                pixel_clk,
    input  logic                rst_n,
    vga_tile_renderer_if.slave  vga
);
    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_PX_W    = $clog2(TILE_W + 1);
    localparam int c_LN_W    = $clog2(TILE_H + 1);
    localparam int c_COL_W   = $clog2(c_H_TOTAL / TILE_W + 2);
    localparam int c_ROW_W   = $clog2(c_V_TOTAL / TILE_H + 2);
    localparam int c_CELLS   = GRID_W * GRID_H;
    localparam int c_CELL_W  = $clog2(c_CELLS);

    localparam logic [c_PX_W-1:0]   c_PX_LAST   = c_PX_W'(TILE_W - 1);
    localparam logic [c_LN_W-1:0]   c_LN_LAST   = c_LN_W'(TILE_H - 1);
    localparam logic [c_COL_W-1:0]  c_GRID_COLS = c_COL_W'(GRID_W);
    localparam logic [c_ROW_W-1:0]  c_GRID_ROWS = c_ROW_W'(GRID_H);
    localparam logic [c_CELL_W-1:0] c_ROW_PITCH = c_CELL_W'(GRID_W);

    // Stage 0: beam counters
    logic w_h_last, w_v_last, w_hsync0, w_vsync0, w_visible0, w_frame_start;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .o_h_last      (w_h_last),
        .o_v_last      (w_v_last),
        .o_hsync       (w_hsync0),
        .o_vsync       (w_vsync0),
        .o_visible     (w_visible0),
        .o_frame_start (w_frame_start)
    );

    logic [c_PX_W-1:0]  r_px;
    logic [c_COL_W-1:0] r_col;
    logic [c_LN_W-1:0]  r_line;
    logic [c_ROW_W-1:0] r_row;

    // Tile counters advance in lock-step with hc/vc, so they describe the same beam position.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px   <= '0;
            r_col  <= '0;
            r_line <= '0;
            r_row  <= '0;
        end else if (w_h_last) begin
            r_px  <= '0;
            r_col <= '0;
            if (w_v_last) begin
                r_line <= '0;
                r_row  <= '0;
            end else if (r_line == c_LN_LAST) begin
                r_line <= '0;
                r_row  <= r_row + 1'b1;
            end else begin
                r_line <= r_line + 1'b1;
            end
        end else if (r_px == c_PX_LAST) begin
            r_px  <= '0;
            r_col <= r_col + 1'b1;
        end else begin
            r_px <= r_px + 1'b1;
        end
    end

    // Frame snapshot, taken at the start of vertical blanking
    logic [2*c_CELLS-1:0] r_arena;
    logic [2*c_CELLS-1:0] r_bomb;
    logic [1:0]           r_go;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arena <= '0;
            r_bomb  <= '0;
            r_go    <= GO_PLAYING;
        end else if (w_frame_start) begin
            r_arena <= vga.arena;
            r_bomb  <= vga.bomb;
            r_go    <= vga.game_over;
        end
    end

    // Stage 1: cell fetch
    logic                w_in_grid;
    logic [c_CELL_W-1:0] w_cell;
    logic [1:0]          w_ac, w_bc;

    assign w_in_grid = (r_col < c_GRID_COLS) && (r_row < c_GRID_ROWS);
    assign w_cell    = c_CELL_W'(r_row) * c_ROW_PITCH + c_CELL_W'(r_col);
    assign w_ac      = 2'(r_arena >> {w_cell, 1'b0});
    assign w_bc      = 2'(r_bomb  >> {w_cell, 1'b0});

    logic [1:0] r_ac1, r_bc1;
    logic       r_in_grid1, r_vis1, r_hs1, r_vs1;
`ifdef VGA_GRID_LINES_EN
    logic       r_edge1;
`endif

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac1      <= 2'd0;
            r_bc1      <= 2'd0;
            r_in_grid1 <= 1'b0;
            r_vis1     <= 1'b0;
            r_hs1      <= 1'b1;
            r_vs1      <= 1'b1;
`ifdef VGA_GRID_LINES_EN
            r_edge1    <= 1'b0;
`endif
        end else begin
            // Out-of-grid positions would index past the plane; force empty.
            r_ac1      <= w_in_grid ? w_ac : 2'd0;
            r_bc1      <= w_in_grid ? w_bc : 2'd0;
            r_in_grid1 <= w_in_grid;
            r_vis1     <= w_visible0;
            r_hs1      <= w_hsync0;
            r_vs1      <= w_vsync0;
`ifdef VGA_GRID_LINES_EN
            r_edge1    <= (r_px == '0) || (r_line == '0);
`endif
        end
    end

    // Stage 2: code merge and palette
    logic [2:0] w_code;
    logic [7:0] r_rgb;
    logic       r_hs2, r_vs2, r_act2;

    assign w_code = cell_code(r_ac1, r_bc1);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb  <= 8'h00;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
            r_act2 <= 1'b0;
        end else begin
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_act2 <= r_vis1;
            if (!r_vis1) begin
                r_rgb <= 8'h00;
            end else if (r_go != GO_PLAYING) begin
                r_rgb <= game_over_colour(r_go);
            end else if (!r_in_grid1) begin
                r_rgb <= 8'h00;
`ifdef VGA_GRID_LINES_EN
            end else if (r_edge1) begin
                r_rgb <= 8'h00;
`endif
            end else begin
                r_rgb <= palette(w_code);
            end
        end
    end

    assign vga.hsync       = r_hs2;
    assign vga.vsync       = r_vs2;
    assign vga.active      = r_act2;
    assign vga.red         = r_rgb[7:5];
    assign vga.green       = r_rgb[4:2];
    assign vga.blue        = r_rgb[1:0];
    assign vga.frame_start = w_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_tile_renderer
//  Description : Scoreboard bench for vga_tile_renderer using a reduced
//                timing set (64 x 39 total, 4x3 tiles, 10x10 grid in a
//                48x32 visible area) so several whole frames fit in a short
//                run. Stimulus queues expected outputs keyed by cycle since
//                reset release; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_tile_renderer;
    localparam int HA = 48, HF = 4, HS = 8, HB = 4;
    localparam int VA = 32, VF = 2, VS = 2, VB = 3;
    localparam int GW = 10, GH = 10, TW = 4, TH = 3;
    localparam int HT = HA + HF + HS + HB;   // 64
    localparam int FR = HT * (VA + VF + VS + VB); // 2496

    logic pixel_clk = 1'b0;
    logic rst_n     = 1'b0;

    vga_tile_renderer_if #(.GRID_W(GW), .GRID_H(GH)) vga_bus ();

    vga_tile_renderer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .GRID_W (GW), .GRID_H (GH), .TILE_W (TW), .TILE_H (TH)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .vga       (vga_bus)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Beam position index since reset release (hc + vc*HT + frame*FR).
    int cyc;
    always @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        logic [11:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    // {frame_start, hsync, vsync, active, rgb[7:0]}
    function automatic logic [11:0] vec(input logic fs, input logic hs, input logic vs,
                                        input logic act, input logic [7:0] rgb);
        return {fs, hs, vs, act, rgb};
    endfunction

    function automatic logic [11:0] observed();
        return {vga_bus.frame_start, vga_bus.hsync, vga_bus.vsync, vga_bus.active,
                vga_bus.red, vga_bus.green, vga_bus.blue};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got fs=%b hs=%b vs=%b act=%b rgb=%h, expected fs=%b hs=%b vs=%b act=%b rgb=%h",
                     name, got[11], got[10], got[9], got[8], got[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic push_raw(input int c, input logic [11:0] e, input string n);
        exp_t item;
        item.cyc  = c;
        item.exp  = e;
        item.name = n;
        sb.push_back(item);
    endtask

    // Pixel (x,y) of frame f appears two clocks after its counter position.
    task automatic push_px(input string n, input int f, input int x, input int y,
                           input logic hs, input logic vs, input logic act, input logic [7:0] rgb);
        push_raw(f * FR + y * HT + x + 2, vec(1'b0, hs, vs, act, rgb), n);
    endtask

    task automatic wait_pos(input int p);
        while (cyc < p) @(negedge pixel_clk);
    endtask

    task automatic wait_empty();
        int guard = 0;
        while (sb.size() > 0 && guard < 3 * FR) begin
            @(negedge pixel_clk);
            guard++;
        end
        n_checks++;
        if (sb.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, next %s at cycle %0d", sb.size(), sb[0].name, sb[0].cyc);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge pixel_clk);
            if (rst_n && sb.size() > 0) begin
                if (sb[0].cyc == cyc) begin
                    check(sb[0].name, observed(), sb[0].exp);
                    void'(sb.pop_front());
                end else if (sb[0].cyc < cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s: missed at cycle %0d, now %0d", sb[0].name, sb[0].cyc, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Watchdog
    initial begin
        repeat (40000) @(posedge pixel_clk);
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Stimulus
    initial begin
        vga_bus.arena       = '0;
        vga_bus.bomb        = '0;
        vga_bus.game_over   = 2'd0;
        vga_bus.arena[1:0]  = 2'd1;     // cell 0 block
        vga_bus.bomb[47:46] = 2'd3;     // cell 23 exploding

        // Frame 0: shadow still cleared, every grid tile is empty (white).
        push_px("f0_px00",       0,  0,  0, 1'b1, 1'b1, 1'b1, 8'hFF);
        push_px("f0_col9",       0, 39,  0, 1'b1, 1'b1, 1'b1, 8'hFF);
        push_px("f0_outgrid_x",  0, 40,  0, 1'b1, 1'b1, 1'b1, 8'h00);
        push_px("f0_last_vis",   0, 47,  0, 1'b1, 1'b1, 1'b1, 8'h00);
        push_px("f0_hs_before",  0, 51,  0, 1'b1, 1'b1, 1'b0, 8'h00);
        push_px("f0_hs_first",   0, 52,  0, 1'b0, 1'b1, 1'b0, 8'h00);
        push_px("f0_hs_last",    0, 59,  0, 1'b0, 1'b1, 1'b0, 8'h00);
        push_px("f0_hs_end",     0, 60,  0, 1'b1, 1'b1, 1'b0, 8'h00);
        push_px("f0_outgrid_y",  0,  5, 30, 1'b1, 1'b1, 1'b1, 8'h00);
        push_raw(2047, vec(1'b0, 1'b1, 1'b1, 1'b0, 8'h00), "f0_fs_pre");
        push_raw(2048, vec(1'b1, 1'b1, 1'b1, 1'b0, 8'h00), "f0_frame_start");
        push_px("f0_vs_before",  0, 63, 33, 1'b1, 1'b1, 1'b0, 8'h00);
        push_px("f0_vs_first",   0,  0, 34, 1'b1, 1'b0, 1'b0, 8'h00);
        push_px("f0_hs_vs_both", 0, 55, 34, 1'b0, 1'b0, 1'b0, 8'h00);
        push_px("f0_vs_last",    0, 63, 35, 1'b1, 1'b0, 1'b0, 8'h00);
        push_px("f0_vs_end",     0,  0, 36, 1'b1, 1'b1, 1'b0, 8'h00);
        // Frame 1: snapshot holds block at cell 0, explosion at cell 23.
        push_px("f1_block00",    1,  0,  0, 1'b1, 1'b1, 1'b1, 8'hDF);
        push_px("f1_col1",       1,  4,  0, 1'b1, 1'b1, 1'b1, 8'hFF);
        push_px("f1_block_edge", 1,  3,  2, 1'b1, 1'b1, 1'b1, 8'hDF);
        push_px("f1_c22",        1, 11,  6, 1'b1, 1'b1, 1'b1, 8'hFF);
        push_px("f1_c23_tl",     1, 12,  6, 1'b1, 1'b1, 1'b1, 8'h3F);
        push_px("f1_c24",        1, 16,  6, 1'b1, 1'b1, 1'b1, 8'hFF);
        push_px("f1_c23_br",     1, 15,  8, 1'b1, 1'b1, 1'b1, 8'h3F);
        push_px("f1_c33",        1, 12,  9, 1'b1, 1'b1, 1'b1, 8'hFF);
        push_px("f1_midchange",  1, 29, 22, 1'b1, 1'b1, 1'b1, 8'hFF);
        // Frame 2: mid-frame-1 arena edits now visible.
        push_px("f2_px00",       2,  0,  0, 1'b1, 1'b1, 1'b1, 8'hFF);
        push_px("f2_c23_p1",     2, 12,  6, 1'b1, 1'b1, 1'b1, 8'hBF);
        push_px("f2_c77_p2",     2, 29, 22, 1'b1, 1'b1, 1'b1, 8'h9F);
        // Frame 3: player 2 wins, solid blue.
        push_px("f3_go_px00",    3,  0,  0, 1'b1, 1'b1, 1'b1, 8'h03);
        push_px("f3_go_outgrid", 3, 47,  0, 1'b1, 1'b1, 1'b1, 8'h03);
        push_px("f3_go_blank",   3, 50,  0, 1'b1, 1'b1, 1'b0, 8'h00);
        push_px("f3_go_hsync",   3, 52,  0, 1'b0, 1'b1, 1'b0, 8'h00);
        push_px("f3_go_mid",     3,  5, 20, 1'b1, 1'b1, 1'b1, 8'h03);

        repeat (4) @(negedge pixel_clk);
        check("reset_state", observed(), vec(1'b0, 1'b1, 1'b1, 1'b0, 8'h00));
        rst_n = 1'b1;

        wait_pos(FR + 20 * HT);
        vga_bus.arena[1:0]     = 2'd0;
        vga_bus.arena[47:46]   = 2'd2;  // cell 23 player 1 over the bomb
        vga_bus.arena[155:154] = 2'd3;  // cell 77 player 2

        wait_pos(2 * FR + 10 * HT);
        vga_bus.game_over = 2'd2;

        wait_pos(3 * FR + 25 * HT + 10);
        wait_empty();
        rst_n = 1'b0;
        #1;
        check("rst_async", observed(), vec(1'b0, 1'b1, 1'b1, 1'b0, 8'h00));
        repeat (3) @(negedge pixel_clk);
        check("rst_hold", observed(), vec(1'b0, 1'b1, 1'b1, 1'b0, 8'h00));

        vga_bus.game_over = 2'd0;
        vga_bus.arena     = '0;
        vga_bus.bomb      = '0;
        vga_bus.bomb[1:0] = 2'd1;       // cell 0 new bomb

        push_px("r_px00",        0,  0,  0, 1'b1, 1'b1, 1'b1, 8'hFF);
        push_px("r_hs_first",    0, 52,  0, 1'b0, 1'b1, 1'b0, 8'h00);
        push_raw(2048, vec(1'b1, 1'b1, 1'b1, 1'b0, 8'h00), "r_frame_start");
        push_px("r_vs_first",    0,  0, 34, 1'b1, 1'b0, 1'b0, 8'h00);
        push_px("r_f1_bomb00",   1,  0,  0, 1'b1, 1'b1, 1'b1, 8'h7F);
        push_px("r_f1_col1",     1,  4,  0, 1'b1, 1'b1, 1'b1, 8'hFF);
        @(negedge pixel_clk);
        rst_n = 1'b1;

        wait_empty();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
- Parametrised VGA timing generator plus tile-map renderer for the BombMan display.
- Snapshots a GRID_W x GRID_H arena plane and bomb plane once per frame, maps each beam position to a tile using incremental counters (no divide/modulo), and outputs registered 8-bit RGB with matched sync delay.
- Replaces the single-resolution, fixed 10x10 renderer.
- Adds per-frame snapshot (no tearing), a game-over screen mode and a frame_start strobe for game logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 29, vertical back porch
- GRID_W, 10, tile columns
- GRID_H, 10, tile rows
- TILE_W, 64, tile width in pixels
- TILE_H, 48, tile height in lines

Ports:
- pixel_clk  in  1  pixel clock (25 MHz at defaults)
- rst_n  in  1  asynchronous reset, active-low
- arena  in  2*GRID_W*GRID_H  arena codes, cell k = row*GRID_W+col at bits [2k+1:2k]; 0 empty, 1 block, 2 player1, 3 player2
- bomb  in  2*GRID_W*GRID_H  bomb codes, same indexing; 0 none, 1 new, 2 armed, 3 exploding
- game_over  in  2  0 playing, 1 player1 wins, 2 player2 wins, 3 draw
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- red  out  3  red
- green  out  3  green
- blue  out  2  blue
- active  out  1  high when the RGB output is a visible pixel
- frame_start  out  1  one-cycle pulse at first vblank line

Behaviour:
Reset (rst_n low, async):
- hc, vc, tile counters and pipeline registers go to 0.
- hsync=1, vsync=1, RGB=0, active=0, frame_start=0.
- Snapshot registers clear to 0.
- Reset may assert mid-frame; after release, scan restarts at hc=0, vc=0.

Timing:
- hc counts 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults).
- vc counts 0..V_TOTAL-1 (521 at defaults) and increments when hc wraps.
- Visible region: hc<H_ACTIVE, vc<V_ACTIVE.
- Sync low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on vc.

Tile addressing:
- col/px_in_tile reset to 0 at hc=0; px_in_tile increments each clock and wraps at TILE_W-1, then col increments.
- row/line_in_tile work the same way on vc, stepping at hc wrap and resetting at vc wrap.
- A position is in the grid when col<GRID_W and row<GRID_H; outside the grid and inside the visible region renders black.

Snapshot:
- On the cycle hc=0, vc=V_ACTIVE, arena, bomb and game_over are registered into shadow registers.
- frame_start pulses on the same cycle.
- Rendering uses only the shadow values, so input changes mid-frame never appear before the next frame.

Pipeline:
- S0: counters.
- S1: cell fetch, ac = shadow arena[cell] and bc = shadow bomb[cell].
- S2: code = ac if ac!=0; else 3+bc if bc!=0; else 0 (3-bit code 0..6).
- RGB is registered from the palette in S2.
- Latency is 2 clocks from the counter value to RGB.
- hsync, vsync and active are delayed by the same 2 stages, so they stay aligned with RGB.

Palette (red, green, blue per code):
- 0: 111,111,11
- 1: 110,111,11
- 2: 101,111,11
- 3: 100,111,11
- 4: 011,111,11
- 5: 010,111,11
- 6: 001,111,11
- Blanking always outputs RGB=0.

Game-over mode (shadow game_over!=0):
- Whole visible region is a solid colour; the tile map is ignored.
- 1: red=111, other channels 0.
- 2: blue=11, other channels 0.
- 3: red=100, green=100, blue=10.

Optional Feature:
- Macro: VGA_GRID_LINES_EN.
- Defined: in-grid pixels with px_in_tile==0 or line_in_tile==0 render 000,000,00 (tile outlines), while playing only.
- Undefined: no outlines, pure palette.
- Latency is unchanged in both cases.

Decomposition:
- Package bombman_vga_pkg holds:
  - cell code localparams (CODE_EMPTY..CODE_EXPLODE = 0..6);
  - game_over encodings;
  - default timing constants;
  - the palette function (3-bit code -> 8-bit RGB).
- One sub-module, vga_timing_gen, owns hc/vc, raw syncs, the visible flag and frame_start.
- The renderer owns the tile counters, snapshot and pipeline.

Test Plan:
- Reset release at defaults -> first hsync low at the cycle count matching hc=656, pulse width 96 clocks. Line period 800, frame period 416800 clocks, vsync low for 2 lines starting at vc=490.
- arena cell 0 = 1, all else 0 -> output pixel (0,0) RGB=110,111,11 appearing 2 clocks after hc=0 with active=1. Pixel (64,0) is 111,111,11.
- arena cell 23 = 0 and bomb cell 23 = 3 -> block at x 192..255, y 96..143 shows 001,111,11. Setting arena cell 23 = 2 instead gives 101,111,11.
- Change arena mid-frame (vc=200) -> current frame unchanged; new value visible only after the frame_start pulse at vc=480.
- game_over=2 during play -> from the next frame the whole visible region is blue=11, red=0, green=0; blanking stays 0.
- Assert rst_n low at vc=300 -> outputs go to reset values immediately. After release, the scan restarts at (0,0) and frame timing is re-verified.
- GRID_W=8, TILE_W=80, VGA_GRID_LINES_EN defined -> tile columns step every 80 pixels; columns 0, 80 and 160 are black on in-grid lines.
